axi_rd_wrap_splitter: RTL and testbench

- Sits directly upstream of the data-width upsizer, which rejects WRAP bursts with SLVERR.
- Rewrites every read WRAP burst into one or two INCR bursts covering the same beats in the same order, so WRAP reads reach the upsizer as legal INCR traffic.
- Merges the two R sub-bursts back into one burst towards the subordinate side, with a single rlast.
- AW, W and B channels pass through combinationally and unchanged.

---
 rtl/axi_rd_wrap_splitter.sv | 232 +++++++++++++++++++++++
 tb/tb_axi_rd_wrap_splitter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_wrap_splitter.sv
// Rewrites AXI read WRAP bursts into one or two INCR bursts and stitches the two R
// sub-bursts back into a single burst; the write channels pass straight through.

package axi_rd_wrap_pkg;

   localparam int unsigned AddrW = 32;
   localparam int unsigned IdW   = 4;
   localparam int unsigned DataW = 32;

   typedef struct packed {
      logic [IdW-1:0]   id;
      logic [AddrW-1:0] addr;
      logic [7:0]       len;
      logic [2:0]       size;
      logic [1:0]       burst;
      logic [3:0]       cache;
   } ar_chan_t;

   typedef ar_chan_t aw_chan_t;

   typedef struct packed {
      logic [DataW-1:0]   data;
      logic [DataW/8-1:0] strb;
      logic               last;
   } w_chan_t;

   typedef struct packed {
      logic [IdW-1:0] id;
      logic [1:0]     resp;
   } b_chan_t;

   typedef struct packed {
      logic [IdW-1:0]   id;
      logic [DataW-1:0] data;
      logic [1:0]       resp;
      logic             last;
   } r_chan_t;

   typedef struct packed {
      aw_chan_t aw;
      logic     aw_valid;
      w_chan_t  w;
      logic     w_valid;
      logic     b_ready;
      ar_chan_t ar;
      logic     ar_valid;
      logic     r_ready;
   } req_t;

   typedef struct packed {
      logic    aw_ready;
      logic    w_ready;
      b_chan_t b;
      logic    b_valid;
      logic    ar_ready;
      r_chan_t r;
      logic    r_valid;
   } rsp_t;

endpackage

module axi_rd_wrap_splitter #(
   parameter int unsigned MaxReads  = 8,
   parameter int unsigned AddrWidth = 32,
   parameter int unsigned IdWidth   = 4,
   parameter type ar_chan_t = axi_rd_wrap_pkg::ar_chan_t,
   parameter type r_chan_t  = axi_rd_wrap_pkg::r_chan_t,
   parameter type axi_req_t = axi_rd_wrap_pkg::req_t,
   parameter type axi_rsp_t = axi_rd_wrap_pkg::rsp_t
) (
   input  logic     clk_i,
   input  logic     rst_i,
   input  axi_req_t sbr_port_req_i,
   output axi_rsp_t sbr_port_rsp_o,
   output axi_req_t mgr_port_req_o,
   input  axi_rsp_t mgr_port_rsp_i
);

   localparam logic [1:0]      BurstIncr = 2'b01;
   localparam logic [1:0]      BurstWrap = 2'b10;
   localparam int unsigned     CntW      = $clog2(MaxReads + 1);
   localparam logic [CntW-1:0] CntMax    = CntW'(MaxReads);

   typedef enum logic [2:0] {
      Idle   = 3'd0,
      Drain  = 3'd1,
      First  = 3'd2,
      Second = 3'd3,
      WaitR  = 3'd4
   } state_e;

   state_e               state_q, state_d;
   logic [CntW-1:0]      cnt_q, cnt_d;
   logic                 first_done_q, first_done_d;
   ar_chan_t             ar_q, ar_d;
   logic [IdWidth-1:0]   id_q, id_d;
   logic [AddrWidth-1:0] low_q, low_d;
   logic [7:0]           off_q, off_d;

   ar_chan_t             ar_in;
   logic [AddrWidth-1:0] tot_in, low_in;
   logic [7:0]           off_in;
   logic                 split_in;

   logic                 not_full, rlast_hs, ar_hs, mask_last;
   r_chan_t              r_sbr;

   // A WRAP burst starting mid-window needs two INCR halves: [addr..top] then [low..addr).
   always_comb begin
      ar_in    = sbr_port_req_i.ar;
      tot_in   = (AddrWidth'(ar_in.len) + AddrWidth'(1)) << ar_in.size;
      low_in   = ar_in.addr & ~(tot_in - AddrWidth'(1));
      off_in   = 8'((ar_in.addr - low_in) >> ar_in.size);
      split_in = (ar_in.burst == BurstWrap) && (ar_in.len != 8'd0) && (off_in != 8'd0);
   end

   always_comb begin
      mgr_port_req_o          = sbr_port_req_i;
      sbr_port_rsp_o          = mgr_port_rsp_i;
      mgr_port_req_o.ar_valid = 1'b0;
      sbr_port_rsp_o.ar_ready = 1'b0;

      state_d      = state_q;
      ar_d         = ar_q;
      id_d         = id_q;
      low_d        = low_q;
      off_d        = off_q;
      first_done_d = first_done_q;

      not_full = (cnt_q != CntMax);
      rlast_hs = mgr_port_rsp_i.r_valid && sbr_port_req_i.r_ready && mgr_port_rsp_i.r.last;

      case (state_q)
         Idle: begin
            if (sbr_port_req_i.ar_valid) begin
               if (split_in) begin
                  state_d = Drain;
               end else begin
                  if (ar_in.burst == BurstWrap) begin
                     mgr_port_req_o.ar.burst = BurstIncr;
                  end
                  mgr_port_req_o.ar_valid = not_full;
                  sbr_port_rsp_o.ar_ready = not_full && mgr_port_rsp_i.ar_ready;
               end
            end
         end
         Drain: begin
            if ((cnt_q == '0) && sbr_port_req_i.ar_valid) begin
               sbr_port_rsp_o.ar_ready = 1'b1;
               ar_d         = ar_in;
               id_d         = ar_in.id;
               low_d        = low_in;
               off_d        = off_in;
               first_done_d = 1'b0;
               state_d      = First;
            end
         end
         First: begin
            mgr_port_req_o.ar       = ar_q;
            mgr_port_req_o.ar.id    = id_q;
            mgr_port_req_o.ar.burst = BurstIncr;
            mgr_port_req_o.ar.len   = ar_q.len - off_q;
            mgr_port_req_o.ar_valid = 1'b1;
            if (mgr_port_rsp_i.ar_ready) begin
               state_d = Second;
            end
         end
         Second: begin
            mgr_port_req_o.ar       = ar_q;
            mgr_port_req_o.ar.id    = id_q;
            mgr_port_req_o.ar.burst = BurstIncr;
            mgr_port_req_o.ar.addr  = low_q;
            mgr_port_req_o.ar.len   = off_q - 8'd1;
            mgr_port_req_o.ar_valid = 1'b1;
            if (mgr_port_rsp_i.ar_ready) begin
               state_d = WaitR;
            end
         end
         WaitR: begin
            if (rlast_hs && first_done_q) begin
               state_d = Idle;
            end
         end
         default: state_d = Idle;
      endcase

      // Only split beats can be in flight here, so the first rlast seen closes the first half.
      mask_last = ((state_q == Second) || (state_q == WaitR)) && !first_done_q;
      if (mask_last && rlast_hs) begin
         first_done_d = 1'b1;
      end
      r_sbr             = mgr_port_rsp_i.r;
      r_sbr.last        = mgr_port_rsp_i.r.last && !mask_last;
      sbr_port_rsp_o.r  = r_sbr;

      ar_hs = mgr_port_req_o.ar_valid && mgr_port_rsp_i.ar_ready;
      cnt_d = cnt_q;
      if (ar_hs && !rlast_hs) begin
         cnt_d = cnt_q + CntW'(1);
      end else if (!ar_hs && rlast_hs) begin
         cnt_d = cnt_q - CntW'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= Idle;
         cnt_q        <= '0;
         first_done_q <= 1'b0;
         ar_q         <= '0;
         id_q         <= '0;
         low_q        <= '0;
         off_q        <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         first_done_q <= first_done_d;
         ar_q         <= ar_d;
         id_q         <= id_d;
         low_q        <= low_d;
         off_q        <= off_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         assert (!(ar_hs && !rlast_hs && (cnt_q == CntMax)));
         assert (!(rlast_hs && !ar_hs && (cnt_q == '0)));
      end
   end

endmodule

// File: tb/tb_axi_rd_wrap_splitter.sv
// Directed bench for axi_rd_wrap_splitter: split/aligned WRAP, drain, backpressure,
// counter-full (MaxReads=2 instance) and reset mid-split.

module tb_axi_rd_wrap_splitter;
   import axi_rd_wrap_pkg::*;

   localparam logic [1:0] INCR = 2'b01;
   localparam logic [1:0] WRAP = 2'b10;

   logic clk;
   logic rst1, rst2;
   req_t sreq, mreq1, mreq2;
   rsp_t mrsp, srsp1, srsp2;

   int n_cmp = 0;
   int n_err = 0;

   axi_rd_wrap_splitter #(.MaxReads(8)) dut1 (
      .clk_i          (clk),
      .rst_i          (rst1),
      .sbr_port_req_i (sreq),
      .sbr_port_rsp_o (srsp1),
      .mgr_port_req_o (mreq1),
      .mgr_port_rsp_i (mrsp)
   );

   axi_rd_wrap_splitter #(.MaxReads(2)) dut2 (
      .clk_i          (clk),
      .rst_i          (rst2),
      .sbr_port_req_i (sreq),
      .sbr_port_rsp_o (srsp2),
      .mgr_port_req_o (mreq2),
      .mgr_port_rsp_i (mrsp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic ar_chan_t mk_ar(input logic [3:0] id, input logic [31:0] addr,
                                      input logic [7:0] len, input logic [2:0] size,
                                      input logic [1:0] burst);
      ar_chan_t a;
      a.id = id; a.addr = addr; a.len = len; a.size = size; a.burst = burst; a.cache = 4'hA;
      return a;
   endfunction

   task automatic ar_set(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
      sreq.ar       = mk_ar(id, addr, len, size, burst);
      sreq.ar_valid = 1'b1;
   endtask

   task automatic r_set(input logic [3:0] id, input logic [31:0] data, input logic last);
      mrsp.r.id   = id;
      mrsp.r.data = data;
      mrsp.r.resp = 2'b00;
      mrsp.r.last = last;
      mrsp.r_valid = 1'b1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   initial begin
      rst1 = 1'b1;
      rst2 = 1'b1;
      sreq = '0;
      sreq.r_ready = 1'b1;
      mrsp = '0;
      mrsp.ar_ready = 1'b1;

      // Reset state
      mid();
      chk("rst_mgr_ar_valid", 64'(mreq1.ar_valid), 64'd0);
      chk("rst_sbr_ar_ready", 64'(srsp1.ar_ready), 64'd0);
      tick();
      rst1 = 1'b0;

      // Split WRAP: len=3 size=2 addr=0x08 -> INCR 0x08 len1, INCR 0x00 len1
      ar_set(4'd5, 32'h08, 8'd3, 3'd2, WRAP);
      mid();
      chk("split_idle_valid", 64'(mreq1.ar_valid), 64'd0);
      chk("split_idle_ready", 64'(srsp1.ar_ready), 64'd0);
      tick();
      mid();
      chk("split_capture_ready", 64'(srsp1.ar_ready), 64'd1);
      tick();
      sreq.ar_valid = 1'b0;
      mid();
      chk("split_first_valid", 64'(mreq1.ar_valid), 64'd1);
      chk("split_first_ar", 64'(mreq1.ar), 64'(mk_ar(4'd5, 32'h08, 8'd1, 3'd2, INCR)));
      tick();
      mid();
      chk("split_second_valid", 64'(mreq1.ar_valid), 64'd1);
      chk("split_second_ar", 64'(mreq1.ar), 64'(mk_ar(4'd5, 32'h00, 8'd1, 3'd2, INCR)));
      tick();
      r_set(4'd5, 32'h11, 1'b0);
      mid();
      chk("split_b1_data", 64'(srsp1.r.data), 64'h11);
      chk("split_b1_last", 64'(srsp1.r.last), 64'd0);
      tick();
      r_set(4'd5, 32'h22, 1'b1);
      mid();
      chk("split_b2_last_masked", 64'(srsp1.r.last), 64'd0);
      tick();
      r_set(4'd5, 32'h33, 1'b0);
      tick();
      r_set(4'd5, 32'h44, 1'b1);
      mid();
      chk("split_b4_last", 64'(srsp1.r.last), 64'd1);
      tick();
      mrsp.r_valid = 1'b0;

      // Aligned WRAP: forwarded as a single INCR
      ar_set(4'd2, 32'h40, 8'd7, 3'd3, WRAP);
      mid();
      chk("aligned_ar", 64'(mreq1.ar), 64'(mk_ar(4'd2, 32'h40, 8'd7, 3'd3, INCR)));
      chk("aligned_valid", 64'(mreq1.ar_valid), 64'd1);
      chk("aligned_ready", 64'(srsp1.ar_ready), 64'd1);
      tick();
      sreq.ar_valid = 1'b0;
      for (int i = 0; i < 7; i++) begin
         r_set(4'd2, 32'(i), 1'b0);
         tick();
      end
      r_set(4'd2, 32'h77, 1'b1);
      mid();
      chk("aligned_last", 64'(srsp1.r.last), 64'd1);
      tick();
      mrsp.r_valid = 1'b0;

      // Drain before split: three INCR reads outstanding
      for (int i = 1; i <= 3; i++) begin
         ar_set(4'(i), 32'h100 * i, 8'd0, 3'd2, INCR);
         mid();
         chk("drain_incr_fwd", 64'(mreq1.ar_valid && srsp1.ar_ready), 64'd1);
         tick();
      end
      ar_set(4'd7, 32'h08, 8'd3, 3'd2, WRAP);
      mid();
      chk("drain_cnt3", 64'(dut1.cnt_q), 64'd3);
      chk("drain_block_ready", 64'(srsp1.ar_ready), 64'd0);
      tick();
      for (int i = 1; i <= 3; i++) begin
         r_set(4'(i), 32'h0, 1'b1);
         mid();
         chk("drain_wait_ready", 64'(srsp1.ar_ready), 64'd0);
         tick();
      end
      mrsp.r_valid = 1'b0;
      mid();
      chk("drain_capture_ready", 64'(srsp1.ar_ready), 64'd1);
      tick();
      ar_set(4'd9, 32'h900, 8'd0, 3'd2, INCR);
      mid();
      chk("drain_first_ar", 64'(mreq1.ar), 64'(mk_ar(4'd7, 32'h08, 8'd1, 3'd2, INCR)));
      chk("drain_first_noaccept", 64'(srsp1.ar_ready), 64'd0);
      tick();
      mid();
      chk("drain_second_ar", 64'(mreq1.ar), 64'(mk_ar(4'd7, 32'h00, 8'd1, 3'd2, INCR)));
      tick();
      r_set(4'd7, 32'h1, 1'b0);
      mid();
      chk("drain_waitr_blocked", 64'(mreq1.ar_valid), 64'd0);
      tick();
      r_set(4'd7, 32'h2, 1'b1);
      mid();
      chk("drain_half1_masked", 64'(srsp1.r.last), 64'd0);
      tick();
      r_set(4'd7, 32'h3, 1'b0);
      tick();
      r_set(4'd7, 32'h4, 1'b1);
      mid();
      chk("drain_half2_last", 64'(srsp1.r.last), 64'd1);
      chk("drain_still_blocked", 64'(mreq1.ar_valid), 64'd0);
      tick();
      mrsp.r_valid = 1'b0;
      mid();
      chk("drain_after_fwd", 64'(mreq1.ar), 64'(mk_ar(4'd9, 32'h900, 8'd0, 3'd2, INCR)));
      chk("drain_after_valid", 64'(mreq1.ar_valid && srsp1.ar_ready), 64'd1);
      tick();
      sreq.ar_valid = 1'b0;
      r_set(4'd9, 32'h9, 1'b1);
      tick();
      mrsp.r_valid = 1'b0;

      // Backpressure on FIRST: len=7 size=2 addr=0x1C -> off=7, halves len 0 and len 6
      mrsp.ar_ready = 1'b0;
      ar_set(4'd3, 32'h1C, 8'd7, 3'd2, WRAP);
      tick();
      mid();
      chk("bp_capture_ready", 64'(srsp1.ar_ready), 64'd1);
      tick();
      sreq.ar_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         mid();
         chk("bp_first_hold_valid", 64'(mreq1.ar_valid), 64'd1);
         chk("bp_first_hold_ar", 64'(mreq1.ar), 64'(mk_ar(4'd3, 32'h1C, 8'd0, 3'd2, INCR)));
         tick();
      end
      mrsp.ar_ready = 1'b1;
      tick();
      mid();
      chk("bp_second_ar", 64'(mreq1.ar), 64'(mk_ar(4'd3, 32'h00, 8'd6, 3'd2, INCR)));
      tick();
      r_set(4'd3, 32'h0, 1'b1);
      mid();
      chk("bp_half1_masked", 64'(srsp1.r.last), 64'd0);
      tick();
      for (int i = 0; i < 6; i++) begin
         r_set(4'd3, 32'(i + 1), 1'b0);
         tick();
      end
      r_set(4'd3, 32'h7, 1'b1);
      mid();
      chk("bp_half2_last", 64'(srsp1.r.last), 64'd1);
      tick();
      mrsp.r_valid = 1'b0;

      // Reset while in SECOND; write channels keep passing through
      sreq.aw = mk_ar(4'd1, 32'h1234, 8'd0, 3'd2, INCR);
      sreq.aw_valid = 1'b1;
      sreq.w.data = 32'hCAFE;
      sreq.w_valid = 1'b1;
      mrsp.b.id = 4'd6;
      mrsp.b_valid = 1'b1;
      mrsp.aw_ready = 1'b1;
      ar_set(4'd5, 32'h08, 8'd3, 3'd2, WRAP);
      tick();
      tick();
      sreq.ar_valid = 1'b0;
      tick();
      mrsp.ar_ready = 1'b0;
      mid();
      chk("rst_in_second", 64'(dut1.state_q), 64'd3);
      chk("rst_second_ar", 64'(mreq1.ar), 64'(mk_ar(4'd5, 32'h00, 8'd1, 3'd2, INCR)));
      rst1 = 1'b1;
      #1;
      chk("rst_async_valid", 64'(mreq1.ar_valid), 64'd0);
      chk("rst_async_state", 64'(dut1.state_q), 64'd0);
      chk("rst_async_cnt", 64'(dut1.cnt_q), 64'd0);
      chk("rst_aw_pass", 64'(mreq1.aw.addr), 64'h1234);
      tick();
      rst1 = 1'b0;
      mid();
      chk("rst_after_state", 64'(dut1.state_q), 64'd0);
      chk("rst_after_valid", 64'(mreq1.ar_valid), 64'd0);
      chk("rst_w_pass", 64'(mreq1.w.data), 64'hCAFE);
      chk("rst_b_pass", 64'(srsp1.b.id), 64'd6);
      chk("rst_awready_pass", 64'(srsp1.aw_ready), 64'd1);
      tick();

      // Counter full on the MaxReads=2 instance
      rst1 = 1'b1;
      rst2 = 1'b0;
      mrsp.ar_ready = 1'b1;
      ar_set(4'd1, 32'h100, 8'd0, 3'd2, INCR);
      mid();
      chk("full_ar1_fwd", 64'(mreq2.ar_valid && srsp2.ar_ready), 64'd1);
      tick();
      ar_set(4'd2, 32'h200, 8'd0, 3'd2, INCR);
      mid();
      chk("full_ar2_fwd", 64'(mreq2.ar_valid && srsp2.ar_ready), 64'd1);
      tick();
      ar_set(4'd3, 32'h300, 8'd0, 3'd2, INCR);
      mid();
      chk("full_cnt2", 64'(dut2.cnt_q), 64'd2);
      chk("full_ar3_stall_valid", 64'(mreq2.ar_valid), 64'd0);
      chk("full_ar3_stall_ready", 64'(srsp2.ar_ready), 64'd0);
      tick();
      r_set(4'd1, 32'h0, 1'b1);
      mid();
      chk("full_stall_during_rlast", 64'(mreq2.ar_valid), 64'd0);
      tick();
      r_set(4'd2, 32'h0, 1'b1);
      mid();
      chk("full_ar3_fwd", 64'(mreq2.ar_valid && srsp2.ar_ready), 64'd1);
      chk("full_cnt_before_both", 64'(dut2.cnt_q), 64'd1);
      tick();
      mrsp.r_valid = 1'b0;
      ar_set(4'd4, 32'h400, 8'd0, 3'd2, INCR);
      mid();
      chk("full_cnt_after_both", 64'(dut2.cnt_q), 64'd1);
      chk("full_ar4_fwd", 64'(mreq2.ar_valid && srsp2.ar_ready), 64'd1);
      tick();
      ar_set(4'd5, 32'h500, 8'd0, 3'd2, INCR);
      mid();
      chk("full_cnt_again", 64'(dut2.cnt_q), 64'd2);
      chk("full_ar5_stall", 64'(mreq2.ar_valid), 64'd0);
      tick();
      sreq.ar_valid = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
